// File: rtl/tcdm_device_adapter.sv
// Bridges a TCDM-style request/response network port to a simple one-cycle peripheral.
// Optional macro TCDM_ADAPTER_WRITE_RESP_EN makes writes return a zero-data response.
module tcdm_device_adapter #(
    parameter int unsigned HostIdxWidth = 1,
    parameter int unsigned AddrWidth    = 12,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned FifoDepth    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [HostIdxWidth-1:0]   req_ini_addr_i,
    input  logic [AddrWidth-1:0]      req_tgt_addr_i,
    input  logic                      req_wen_i,
    input  logic [DataWidth-1:0]      req_wdata_i,
    input  logic [DataWidth/8-1:0]    req_be_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [HostIdxWidth-1:0]   resp_ini_addr_o,
    output logic [DataWidth-1:0]      resp_rdata_o,
    output logic                      dev_req_o,
    output logic                      dev_we_o,
    output logic [DataWidth/8-1:0]    dev_be_o,
    output logic [AddrWidth-1:0]      dev_addr_o,
    output logic [DataWidth-1:0]      dev_wdata_o,
    input  logic                      dev_rvalid_i,
    input  logic [DataWidth-1:0]      dev_rdata_i,
    output logic                      err_o
);
    localparam int unsigned PtrWidth   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntWidth   = $clog2(FifoDepth + 2);
    localparam int unsigned EntryWidth = HostIdxWidth + DataWidth;

    logic [EntryWidth-1:0]   mem_q [FifoDepth];
    logic [PtrWidth-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntWidth-1:0]     occ_q, occ_d, count_d;
    logic                    tag_valid_q, tag_valid_d;
    logic                    tag_wen_q, tag_wen_d;
    logic [HostIdxWidth-1:0] tag_ini_q, tag_ini_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic                    accept, push, pop;
    logic [DataWidth-1:0]    push_data;
    logic [EntryWidth-1:0]   head;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign accept      = req_valid_i & ready_q;
    assign req_ready_o = ready_q;
    assign dev_req_o   = accept;
    assign dev_we_o    = req_wen_i;
    assign dev_be_o    = req_be_i;
    assign dev_addr_o  = req_tgt_addr_i;
    assign dev_wdata_o = req_wdata_i;
    assign err_o       = err_q;

    assign head            = mem_q[rptr_q];
    assign resp_valid_o    = (occ_q != '0);
    assign resp_ini_addr_o = resp_valid_o ? head[EntryWidth-1:DataWidth] : '0;
    assign resp_rdata_o    = resp_valid_o ? head[DataWidth-1:0] : '0;
    assign pop             = resp_valid_o & resp_ready_i;

`ifdef TCDM_ADAPTER_WRITE_RESP_EN
    assign push      = dev_rvalid_i & tag_valid_q;
    assign push_data = tag_wen_q ? '0 : dev_rdata_i;
`else
    // Write completions only return their credit; nothing is queued for them.
    assign push      = dev_rvalid_i & tag_valid_q & ~tag_wen_q;
    assign push_data = dev_rdata_i;
`endif

    always_comb begin
        tag_valid_d = accept;
        tag_ini_d   = accept ? req_ini_addr_i : tag_ini_q;
        tag_wen_d   = accept ? req_wen_i : tag_wen_q;
        wptr_d      = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d      = pop ? ptr_inc(rptr_q) : rptr_q;
        occ_d       = occ_q + CntWidth'(push) - CntWidth'(pop);
        // An in-flight access always ends after one cycle (answered or flagged),
        // so its credit is simply replaced by whatever is accepted now.
        count_d     = occ_d + CntWidth'(tag_valid_d);
        ready_d     = (count_d < CntWidth'(FifoDepth));
        err_d       = err_q | (dev_rvalid_i & ~tag_valid_q) | (tag_valid_q & ~dev_rvalid_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            occ_q       <= '0;
            tag_valid_q <= 1'b0;
            tag_wen_q   <= 1'b0;
            tag_ini_q   <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
            tag_valid_q <= tag_valid_d;
            tag_wen_q   <= tag_wen_d;
            tag_ini_q   <= tag_ini_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= {tag_ini_q, push_data};
        end
    end
endmodule

// File: tb/tb_tcdm_device_adapter.sv
// Randomized bench for tcdm_device_adapter against a queue-based model of the credit/FIFO rules.
module tb_tcdm_device_adapter;
    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i, req_ready_o, req_wen_i;
    logic [0:0]  req_ini_addr_i;
    logic [11:0] req_tgt_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        resp_valid_o, resp_ready_i;
    logic [0:0]  resp_ini_addr_o;
    logic [31:0] resp_rdata_o;
    logic        dev_req_o, dev_we_o;
    logic [3:0]  dev_be_o;
    logic [11:0] dev_addr_o;
    logic [31:0] dev_wdata_o;
    logic        dev_rvalid_i;
    logic [31:0] dev_rdata_i;
    logic        err_o;

    tcdm_device_adapter #(
        .HostIdxWidth(1), .AddrWidth(12), .DataWidth(32), .FifoDepth(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_ini_addr_i(req_ini_addr_i), .req_tgt_addr_i(req_tgt_addr_i),
        .req_wen_i(req_wen_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_ini_addr_o(resp_ini_addr_o), .resp_rdata_o(resp_rdata_o),
        .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_be_o(dev_be_o),
        .dev_addr_o(dev_addr_o), .dev_wdata_o(dev_wdata_o),
        .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Peripheral memory (word-indexed by addr[5:2]) and its one-cycle answer.
    logic [31:0] pmem [16];
    logic        pend, pend_we;
    logic [31:0] pend_data;

    // Reference model: response queue, single in-flight slot, sticky error.
    logic [32:0] m_q [$];
    logic        m_inf, m_wen, m_err;
    logic [0:0]  m_ini;
    logic [31:0] m_data;

    logic [85:0] act_vec, exp_vec;

    task automatic idle_inputs();
        req_valid_i = 0; req_wen_i = 0; req_ini_addr_i = 0; req_tgt_addr_i = 0;
        req_wdata_i = 0; req_be_i = 0; resp_ready_i = 0; dev_rvalid_i = 0; dev_rdata_i = 0;
    endtask

    task automatic assert_reset();
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        idle_inputs();
        pend = 0; pend_we = 0;
        m_q.delete(); m_inf = 0; m_err = 0; m_wen = 0; m_ini = 0; m_data = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // One clock of stimulus; fills act_vec/exp_vec and advances the model.
    task automatic do_cycle(input logic v, input logic we, input logic [11:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, input logic [0:0] ini,
                            input logic rr, input logic spur, input logic drop);
        logic m_ready, acc, rv;
        logic [32:0] head;
        @(negedge clk_i);
        req_valid_i = v; req_wen_i = we; req_tgt_addr_i = addr; req_wdata_i = wd;
        req_be_i = be; req_ini_addr_i = ini; resp_ready_i = rr;
        rv = (pend & ~drop) | spur;
        dev_rvalid_i = rv;
        dev_rdata_i = (pend && !pend_we) ? pend_data : $urandom;
        #1;
        m_ready = (m_q.size() + int'(m_inf)) < DEPTH;
        acc = v & m_ready;
        head = (m_q.size() != 0) ? m_q[0] : 33'h0;
        exp_vec = {m_ready, acc, we, be, addr, wd, (m_q.size() != 0), head, m_err};
        act_vec = {req_ready_o, dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o,
                   resp_valid_o, resp_ini_addr_o, resp_rdata_o, err_o};
        if (dev_req_o) begin
            if (dev_we_o)
                for (int b = 0; b < 4; b++)
                    if (dev_be_o[b]) pmem[dev_addr_o[5:2]][8*b +: 8] = dev_wdata_o[8*b +: 8];
            pend_data = pmem[dev_addr_o[5:2]];
        end
        pend = dev_req_o; pend_we = dev_we_o;
        if (m_q.size() != 0 && rr) void'(m_q.pop_front());
        if (rv != m_inf) m_err = 1'b1;
        if (rv && m_inf) begin
            if (!m_wen) m_q.push_back({m_ini, m_data});
`ifdef TCDM_ADAPTER_WRITE_RESP_EN
            else m_q.push_back({m_ini, 32'h0});
`endif
        end
        m_inf = acc; m_ini = ini; m_wen = we; m_data = pmem[addr[5:2]];
    endtask

    task automatic test_reset();
        assert_reset();
        #1;
        vectors++;
        if ({req_ready_o, resp_valid_o, resp_ini_addr_o, resp_rdata_o, err_o} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0",
                     {req_ready_o, resp_valid_o, resp_ini_addr_o, resp_rdata_o, err_o});
        end
        release_reset();
        for (int c = 0; c < 2; c++) begin
            do_cycle(0, 0, 12'($urandom), $urandom, 4'($urandom), 1'($urandom), 1, 0, 0);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL after_reset c%0d: got %h required %h", c, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_read_latency();
        pmem[4] = 32'hDEADBEEF;
        for (int c = 0; c < 4; c++) begin
            do_cycle(c == 0, 0, 12'h010, $urandom, 4'hF, 1'b0, 1, 0, 0);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL read_latency c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            if (c == 2) begin
                vectors++;
                if ({resp_valid_o, resp_ini_addr_o, resp_rdata_o} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
                    miscompares++;
                    $display("FAIL read_resp_n2: got %h required 1_0_deadbeef",
                             {resp_valid_o, resp_ini_addr_o, resp_rdata_o});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int accepts = 0, first_pop = -1, third_acc = -1, c = 0;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, 0, 12'(4 * i + 32), $urandom, 4'hF, 1'(i), 0, 0, 0);
            accepts += int'(dev_req_o);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL backpressure_fill c%0d: got %h required %h", i, act_vec, exp_vec);
            end
        end
        vectors++;
        if (accepts != 2 || req_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_credit: got accepts=%0d ready=%b required 2/0", accepts, req_ready_o);
        end
        while ((third_acc < 0 || m_q.size() != 0 || m_inf) && c < 20) begin
            do_cycle(third_acc < 0, 0, 12'h028, $urandom, 4'hF, 1'b0, 1, 0, 0);
            if (first_pop < 0 && resp_valid_o) first_pop = c;
            if (third_acc < 0 && dev_req_o) third_acc = c;
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL backpressure_drain c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            c++;
        end
        vectors++;
        if (first_pop < 0 || third_acc != first_pop + 1) begin
            miscompares++;
            $display("FAIL third_accept: got pop=%0d accept=%0d required accept=pop+1", first_pop, third_acc);
        end
    endtask

    task automatic test_write();
        for (int c = 0; c < 3; c++) begin
            do_cycle(c == 0, c == 0, 12'h004, 32'h12345678, 4'hF, 1'b0, 1, 0, 0);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL write c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            if (c == 0) begin
                vectors++;
                if ({dev_req_o, dev_we_o, dev_wdata_o} !== {2'b11, 32'h12345678}) begin
                    miscompares++;
                    $display("FAIL write_dev: got %h required 3_12345678", {dev_req_o, dev_we_o, dev_wdata_o});
                end
            end
            if (c == 2) begin
                vectors++;
`ifdef TCDM_ADAPTER_WRITE_RESP_EN
                if ({resp_valid_o, resp_rdata_o} !== {1'b1, 32'h0}) begin
                    miscompares++;
                    $display("FAIL write_resp: got %h required 1_00000000", {resp_valid_o, resp_rdata_o});
                end
`else
                if ({resp_valid_o, req_ready_o} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL write_noresp: got valid/ready %b required 01", {resp_valid_o, req_ready_o});
                end
`endif
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            do_cycle(1, 0, 12'($urandom), $urandom, 4'($urandom), 1'($urandom), 1, 0, 0);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL back_to_back c%0d: got %h required %h", c, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            do_cycle(1'($urandom), 1'($urandom), 12'($urandom), $urandom, 4'($urandom),
                     1'($urandom), ($urandom_range(0, 3) != 0), 0, 0);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random c%0d: got %h required %h", c, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_spurious();
        assert_reset();
        release_reset();
        for (int c = 0; c < 5; c++) begin
            do_cycle(0, 0, 12'h0, 32'h0, 4'h0, 1'b0, 1, c == 1, 0);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL spurious c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            if (c >= 2) begin
                vectors++;
                if ({err_o, resp_valid_o} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL spurious_err c%0d: got err/valid %b required 10", c, {err_o, resp_valid_o});
                end
            end
        end
        assert_reset();
        #1;
        vectors++;
        if (err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got %b required 0", err_o);
        end
        release_reset();
    endtask

    task automatic test_missing_rvalid();
        for (int c = 0; c < 4; c++) begin
            do_cycle(c == 0, 0, 12'h008, 32'h0, 4'hF, 1'b1, 1, 0, c == 1);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL missing c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            if (c == 2) begin
                vectors++;
                if ({err_o, req_ready_o, resp_valid_o} !== 3'b110) begin
                    miscompares++;
                    $display("FAIL missing_credit: got err/ready/valid %b required 110",
                             {err_o, req_ready_o, resp_valid_o});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        assert_reset();
        release_reset();
        for (int c = 0; c < 4; c++) begin
            do_cycle(c < 2, 0, 12'(8 * c), $urandom, 4'hF, 1'(c), 0, 0, 0);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_mid_fill c%0d: got %h required %h", c, act_vec, exp_vec);
            end
        end
        assert_reset();
        #1;
        vectors++;
        if ({resp_valid_o, req_ready_o, resp_rdata_o, resp_ini_addr_o, err_o} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_mid_flush: got %h required 0",
                     {resp_valid_o, req_ready_o, resp_rdata_o, resp_ini_addr_o, err_o});
        end
        release_reset();
        for (int c = 0; c < 4; c++) begin
            do_cycle(0, 0, 12'h0, 32'h0, 4'h0, 1'b0, 1, 0, 0);
            vectors++;
            if (act_vec !== exp_vec || resp_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_after c%0d: got %h required %h", c, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        idle_inputs();
        pend = 0; pend_we = 0; pend_data = 0;
        m_inf = 0; m_err = 0; m_wen = 0; m_ini = 0; m_data = 0;
        for (int i = 0; i < 16; i++) pmem[i] = $urandom;
        test_reset();
        test_read_latency();
        test_backpressure();
        test_write();
        test_back_to_back();
        test_random();
        test_spurious();
        test_missing_rvalid();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
